// File: rtl/gnrc_rr_arbiter_if.sv
// Requester-side and manager-side bundles for gnrc_rr_arbiter.
// The arbiter connects to the slave modport of the requester bundle and to
// the master modport of the manager bundle.

interface gnrc_rr_req_if #(
  parameter int unsigned N     = 1,
  parameter type         DTYPE = logic
);
  logic [N-1:0] req_i;
  logic [N-1:0] lock_i;
  logic [N-1:0] gnt_o;
  DTYPE         data_i [N];

  modport master (output req_i, lock_i, data_i, input gnt_o);
  modport slave  (input req_i, lock_i, data_i, output gnt_o);
endinterface

interface gnrc_rr_mgr_if #(
  parameter int unsigned N     = 1,
  parameter type         DTYPE = logic
);
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

  logic          req_o;
  logic          lock_o;
  DTYPE          data_o;
  logic [AW-1:0] idx_o;
  logic          gnt_i;

  modport master (output req_o, lock_o, data_o, idx_o, input gnt_i);
  modport slave  (input req_o, lock_o, data_o, idx_o, output gnt_i);
endinterface

// File: rtl/gnrc_rr_arbiter.sv
// N-to-1 round-robin arbiter with per-transaction locking, payload mux and
// optional output buffering (DEPTH 0/1/2).
// Optional checks: define GNRC_ARBITER_ASSERT_EN to enable simulation assertions.

module gnrc_rr_arbiter #(
  parameter int unsigned N      = 1,
  parameter bit          EXT_RR = 1'b0,
  parameter bit          LEAKY  = 1'b1,
  parameter int unsigned DEPTH  = 0,
  parameter type         DTYPE  = logic
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [N-1:0]  rr_i,
  gnrc_rr_req_if.slave  req_bus,
  gnrc_rr_mgr_if.master mgr_bus
);

  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

  logic [AW-1:0] ptr_q;
  logic          lock_q;
  logic [AW-1:0] lock_idx_q;
  logic          hold_q;
  logic [AW-1:0] hold_idx_q;

  logic [AW-1:0] start_c;
  logic [AW:0]   pick_c;
  logic [AW-1:0] win_idx_c;
  logic          win_vld_c;
  logic          win_lock_c;
  DTYPE          win_data_c;
  logic          ready_c;
  logic          take_c;
  logic [AW-1:0] ptr_next_c;

  // First requester at or above start, wrapping; MSB of result = found.
  function automatic logic [AW:0] rr_pick(input logic [N-1:0] req,
                                          input logic [AW-1:0] start);
    logic [AW:0] res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(start) + i) % N;
      if (!res[AW] && req[AW'(k)]) res = {1'b1, AW'(k)};
    end
    return res;
  endfunction

  // Priority start: external one-hot pointer or internal round-robin pointer.
  always_comb begin
    start_c = ptr_q;
    if (EXT_RR) begin
      start_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (rr_i[i]) start_c = AW'(i);
      end
    end
  end

  // Winner selection; a lock or a pending non-leaky request pins the choice.
  always_comb begin
    pick_c    = rr_pick(req_bus.req_i, start_c);
    win_idx_c = pick_c[AW-1:0];
    win_vld_c = pick_c[AW];
    if (lock_q) begin
      win_idx_c = lock_idx_q;
      win_vld_c = req_bus.req_i[lock_idx_q];
    end else if (hold_q) begin
      win_idx_c = hold_idx_q;
      win_vld_c = req_bus.req_i[hold_idx_q];
    end
    win_lock_c = win_vld_c & req_bus.lock_i[win_idx_c];
    win_data_c = req_bus.data_i[win_idx_c];
  end

  assign take_c     = win_vld_c & ready_c & ~rst_i;
  assign ptr_next_c = (win_idx_c == AW'(N - 1)) ? '0 : win_idx_c + AW'(1);

  // Grant goes back only to the winner, and only when its beat is taken.
  always_comb begin
    req_bus.gnt_o = '0;
    if (take_c) req_bus.gnt_o[win_idx_c] = 1'b1;
  end

  // Pointer and lock state; flush beats a simultaneous accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i && !EXT_RR) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
    end else if (take_c) begin
      lock_q     <= win_lock_c;
      lock_idx_q <= win_idx_c;
      if (!win_lock_c) ptr_q <= ptr_next_c;
    end
  end

  // Non-leaky combinational mode: keep an ungranted selection until gnt_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else if (LEAKY || DEPTH != 0) begin
      hold_q <= 1'b0;
    end else begin
      hold_q     <= win_vld_c & ~mgr_bus.gnt_i & ~lock_q;
      hold_idx_q <= win_idx_c;
    end
  end

  if (DEPTH == 0) begin : g_comb
    assign ready_c        = mgr_bus.gnt_i;
    assign mgr_bus.req_o  = win_vld_c;
    assign mgr_bus.lock_o = win_lock_c;
    assign mgr_bus.idx_o  = win_vld_c ? win_idx_c : '0;
    assign mgr_bus.data_o = win_vld_c ? win_data_c : '0;
  end else if (DEPTH == 1) begin : g_reg
    logic          o_vld_q;
    logic          o_lock_q;
    logic [AW-1:0] o_idx_q;
    DTYPE          o_data_q;

    assign ready_c = ~o_vld_q | mgr_bus.gnt_i;

    // Single output register, refilled in the cycle it drains.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        o_vld_q  <= 1'b0;
        o_lock_q <= 1'b0;
        o_idx_q  <= '0;
        o_data_q <= '0;
      end else if (take_c) begin
        o_vld_q  <= 1'b1;
        o_lock_q <= win_lock_c;
        o_idx_q  <= win_idx_c;
        o_data_q <= win_data_c;
      end else if (mgr_bus.gnt_i) begin
        o_vld_q <= 1'b0;
      end
    end

    assign mgr_bus.req_o  = o_vld_q;
    assign mgr_bus.lock_o = o_lock_q;
    assign mgr_bus.idx_o  = o_idx_q;
    assign mgr_bus.data_o = o_data_q;
  end else begin : g_skid
    logic          o_vld_q, s_vld_q;
    logic          o_lock_q, s_lock_q;
    logic [AW-1:0] o_idx_q, s_idx_q;
    DTYPE          o_data_q, s_data_q;

    assign ready_c = ~s_vld_q;

    // Output entry plus skid entry; ready depends only on the skid slot.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        o_vld_q  <= 1'b0;
        o_lock_q <= 1'b0;
        o_idx_q  <= '0;
        o_data_q <= '0;
        s_vld_q  <= 1'b0;
        s_lock_q <= 1'b0;
        s_idx_q  <= '0;
        s_data_q <= '0;
      end else if (!o_vld_q || mgr_bus.gnt_i) begin
        if (s_vld_q) begin
          o_vld_q  <= 1'b1;
          o_lock_q <= s_lock_q;
          o_idx_q  <= s_idx_q;
          o_data_q <= s_data_q;
          s_vld_q  <= 1'b0;
        end else begin
          o_vld_q <= take_c;
          if (take_c) begin
            o_lock_q <= win_lock_c;
            o_idx_q  <= win_idx_c;
            o_data_q <= win_data_c;
          end
        end
      end else if (take_c) begin
        s_vld_q  <= 1'b1;
        s_lock_q <= win_lock_c;
        s_idx_q  <= win_idx_c;
        s_data_q <= win_data_c;
      end
    end

    assign mgr_bus.req_o  = o_vld_q;
    assign mgr_bus.lock_o = o_lock_q;
    assign mgr_bus.idx_o  = o_idx_q;
    assign mgr_bus.data_o = o_data_q;
  end

`ifdef GNRC_ARBITER_ASSERT_EN
  if (N < 1) begin : g_bad_n
    $fatal(1, "gnrc_rr_arbiter: N must be at least 1");
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_bus.gnt_o));

  a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (mgr_bus.req_o && !mgr_bus.gnt_i) |=> mgr_bus.req_o);

  if (DEPTH >= 1 || !LEAKY) begin : g_stable
    a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (mgr_bus.req_o && !mgr_bus.gnt_i) |=> $stable(mgr_bus.data_o));
  end
`else
  // Checks compiled out; datapath is unaffected.
`endif

endmodule

// File: tb/tb_gnrc_rr_arbiter.sv
// Directed bench for gnrc_rr_arbiter: external priority, internal
// round-robin, locking, flush, non-leaky hold, DEPTH=1 and DEPTH=2 stages.

module tb_gnrc_rr_arbiter;

  typedef logic [7:0] byte_t;

  logic       clk;
  logic       rst;
  logic       flush_rr;
  logic       zero1;
  logic [3:0] rr;
  logic [3:0] zero4;

  int checks;
  int errors;

  gnrc_rr_req_if #(.N(4), .DTYPE(byte_t)) rq_ext ();
  gnrc_rr_mgr_if #(.N(4), .DTYPE(byte_t)) mg_ext ();
  gnrc_rr_req_if #(.N(4), .DTYPE(byte_t)) rq_rr ();
  gnrc_rr_mgr_if #(.N(4), .DTYPE(byte_t)) mg_rr ();
  gnrc_rr_req_if #(.N(4), .DTYPE(byte_t)) rq_nl ();
  gnrc_rr_mgr_if #(.N(4), .DTYPE(byte_t)) mg_nl ();
  gnrc_rr_req_if #(.N(4), .DTYPE(byte_t)) rq_d1 ();
  gnrc_rr_mgr_if #(.N(4), .DTYPE(byte_t)) mg_d1 ();
  gnrc_rr_req_if #(.N(4), .DTYPE(byte_t)) rq_d2 ();
  gnrc_rr_mgr_if #(.N(4), .DTYPE(byte_t)) mg_d2 ();

  gnrc_rr_arbiter #(.N(4), .EXT_RR(1'b1), .LEAKY(1'b1), .DEPTH(0), .DTYPE(byte_t)) u_ext (
    .clk_i(clk), .rst_i(rst), .flush_i(zero1), .rr_i(rr), .req_bus(rq_ext), .mgr_bus(mg_ext));
  gnrc_rr_arbiter #(.N(4), .EXT_RR(1'b0), .LEAKY(1'b1), .DEPTH(0), .DTYPE(byte_t)) u_rr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_rr), .rr_i(zero4), .req_bus(rq_rr), .mgr_bus(mg_rr));
  gnrc_rr_arbiter #(.N(4), .EXT_RR(1'b0), .LEAKY(1'b0), .DEPTH(0), .DTYPE(byte_t)) u_nl (
    .clk_i(clk), .rst_i(rst), .flush_i(zero1), .rr_i(zero4), .req_bus(rq_nl), .mgr_bus(mg_nl));
  gnrc_rr_arbiter #(.N(4), .EXT_RR(1'b0), .LEAKY(1'b1), .DEPTH(1), .DTYPE(byte_t)) u_d1 (
    .clk_i(clk), .rst_i(rst), .flush_i(zero1), .rr_i(zero4), .req_bus(rq_d1), .mgr_bus(mg_d1));
  gnrc_rr_arbiter #(.N(4), .EXT_RR(1'b0), .LEAKY(1'b1), .DEPTH(2), .DTYPE(byte_t)) u_d2 (
    .clk_i(clk), .rst_i(rst), .flush_i(zero1), .rr_i(zero4), .req_bus(rq_d2), .mgr_bus(mg_d2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    flush_rr = 1'b0;
    zero1    = 1'b0;
    zero4    = 4'b0000;
    rr       = 4'b0000;
    rq_ext.req_i = '0; rq_ext.lock_i = '0; mg_ext.gnt_i = 1'b0;
    rq_rr.req_i  = '0; rq_rr.lock_i  = '0; mg_rr.gnt_i  = 1'b0;
    rq_nl.req_i  = '0; rq_nl.lock_i  = '0; mg_nl.gnt_i  = 1'b0;
    rq_d1.req_i  = '0; rq_d1.lock_i  = '0; mg_d1.gnt_i  = 1'b0;
    rq_d2.req_i  = '0; rq_d2.lock_i  = '0; mg_d2.gnt_i  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rq_ext.data_i[k] = byte_t'(8'hA0 + k);
      rq_rr.data_i[k]  = byte_t'(8'hA0 + k);
      rq_nl.data_i[k]  = byte_t'(8'hA0 + k);
      rq_d1.data_i[k]  = byte_t'(8'hA0 + k);
      rq_d2.data_i[k]  = byte_t'(8'hA0 + k);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_d1_req",  32'(mg_d1.req_o), 32'd0);
    chk("rst_d1_idx",  32'(mg_d1.idx_o), 32'd0);
    chk("rst_d1_data", 32'(mg_d1.data_o), 32'd0);
    chk("rst_d1_lock", 32'(mg_d1.lock_o), 32'd0);
    chk("rst_d2_req",  32'(mg_d2.req_o), 32'd0);
    chk("rst_d2_data", 32'(mg_d2.data_o), 32'd0);
    chk("rst_rr_req",  32'(mg_rr.req_o), 32'd0);
    chk("rst_rr_gnt",  32'(rq_rr.gnt_o), 32'd0);

    // External priority, fixed LSB-first when rr_i is zero
    rq_ext.req_i = 4'b1010; mg_ext.gnt_i = 1'b1; rr = 4'b0000;
    #1;
    chk("ext0_req",  32'(mg_ext.req_o), 32'd1);
    chk("ext0_idx",  32'(mg_ext.idx_o), 32'd1);
    chk("ext0_gnt",  32'(rq_ext.gnt_o), 32'b0010);
    chk("ext0_data", 32'(mg_ext.data_o), 32'hA1);
    rr = 4'b0100;
    #1;
    chk("ext2_idx",  32'(mg_ext.idx_o), 32'd3);
    chk("ext2_gnt",  32'(rq_ext.gnt_o), 32'b1000);
    chk("ext2_data", 32'(mg_ext.data_o), 32'hA3);
    rr = 4'b0001;
    #1;
    chk("ext1_idx",  32'(mg_ext.idx_o), 32'd1);
    mg_ext.gnt_i = 1'b0;
    #1;
    chk("ext_nognt", 32'(rq_ext.gnt_o), 32'd0);
    rq_ext.req_i = 4'b0000;

    // Internal round-robin, all requesting
    rq_rr.req_i = 4'b1111; mg_rr.gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_idx", 32'(mg_rr.idx_o), 32'(i % 4));
      chk("rr_gnt", 32'(rq_rr.gnt_o), 32'd1 << (i % 4));
      tick();
    end

    // Lock: requester 0 sends lock 1,1,0 while requester 1 waits
    rq_rr.req_i = 4'b0011; rq_rr.lock_i = 4'b0001;
    #1;
    chk("lk1_idx",  32'(mg_rr.idx_o), 32'd0);
    chk("lk1_lock", 32'(mg_rr.lock_o), 32'd1);
    chk("lk1_gnt",  32'(rq_rr.gnt_o), 32'b0001);
    tick();
    rq_rr.req_i = 4'b0010;
    #1;
    chk("lkdrop_req", 32'(mg_rr.req_o), 32'd0);
    chk("lkdrop_gnt", 32'(rq_rr.gnt_o), 32'd0);
    tick();
    rq_rr.req_i = 4'b0011;
    #1;
    chk("lk2_idx", 32'(mg_rr.idx_o), 32'd0);
    tick();
    rq_rr.lock_i = 4'b0000;
    #1;
    chk("lk3_idx",  32'(mg_rr.idx_o), 32'd0);
    chk("lk3_lock", 32'(mg_rr.lock_o), 32'd0);
    chk("lk3_gnt",  32'(rq_rr.gnt_o), 32'b0001);
    tick();
    #1;
    chk("lkdone_idx", 32'(mg_rr.idx_o), 32'd1);
    chk("lkdone_gnt", 32'(rq_rr.gnt_o), 32'b0010);
    tick();

    // Flush in the middle of a lock (pointer is 2 here)
    rq_rr.lock_i = 4'b0001;
    #1;
    chk("fl_pre_idx", 32'(mg_rr.idx_o), 32'd0);
    tick();
    flush_rr = 1'b1;
    #1;
    chk("fl_gnt", 32'(rq_rr.gnt_o), 32'b0001);
    tick();
    flush_rr = 1'b0; rq_rr.req_i = 4'b1010; rq_rr.lock_i = 4'b0000; mg_rr.gnt_i = 1'b0;
    #1;
    chk("fl_post_req", 32'(mg_rr.req_o), 32'd1);
    chk("fl_post_idx", 32'(mg_rr.idx_o), 32'd1);
    rq_rr.req_i = 4'b0000;

    // Non-leaky selection held until gnt_i
    rq_nl.req_i = 4'b0010; mg_nl.gnt_i = 1'b0;
    #1;
    chk("nl_a_idx", 32'(mg_nl.idx_o), 32'd1);
    tick();
    rq_nl.req_i = 4'b0011;
    #1;
    chk("nl_hold_idx", 32'(mg_nl.idx_o), 32'd1);
    tick();
    mg_nl.gnt_i = 1'b1;
    #1;
    chk("nl_gnt", 32'(rq_nl.gnt_o), 32'b0010);
    tick();
    mg_nl.gnt_i = 1'b0;
    #1;
    chk("nl_next_idx", 32'(mg_nl.idx_o), 32'd0);
    rq_nl.req_i = 4'b0000;

    // DEPTH=1: stalled beat held stable, grant pulses once
    rq_d1.req_i = 4'b0100; rq_d1.data_i[2] = 8'hC2; mg_d1.gnt_i = 1'b0;
    #1;
    chk("d1_take_gnt", 32'(rq_d1.gnt_o), 32'b0100);
    chk("d1_lat_req",  32'(mg_d1.req_o), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      rq_d1.data_i[2] = byte_t'(8'h50 + i);
      #1;
      chk("d1_stall_req",  32'(mg_d1.req_o), 32'd1);
      chk("d1_stall_idx",  32'(mg_d1.idx_o), 32'd2);
      chk("d1_stall_data", 32'(mg_d1.data_o), 32'hC2);
      chk("d1_stall_gnt",  32'(rq_d1.gnt_o), 32'd0);
      tick();
    end
    rq_d1.req_i = 4'b0000; mg_d1.gnt_i = 1'b1;
    #1;
    chk("d1_drain_data", 32'(mg_d1.data_o), 32'hC2);
    chk("d1_drain_gnt",  32'(rq_d1.gnt_o), 32'd0);
    tick();
    #1;
    chk("d1_empty_req", 32'(mg_d1.req_o), 32'd0);

    // DEPTH=1 back-to-back (pointer is 3), then reset mid-stream
    rq_d1.data_i[2] = 8'hA2; rq_d1.req_i = 4'b1111; rq_d1.lock_i = 4'b0000;
    #1;
    chk("d1_c0_gnt", 32'(rq_d1.gnt_o), 32'b1000);
    tick();
    rq_d1.lock_i = 4'b0001;
    #1;
    chk("d1_c1_idx",  32'(mg_d1.idx_o), 32'd3);
    chk("d1_c1_data", 32'(mg_d1.data_o), 32'hA3);
    chk("d1_c1_gnt",  32'(rq_d1.gnt_o), 32'b0001);
    tick();
    mg_d1.gnt_i = 1'b0;
    #1;
    chk("d1_c2_idx",  32'(mg_d1.idx_o), 32'd0);
    chk("d1_c2_lock", 32'(mg_d1.lock_o), 32'd1);
    chk("d1_c2_gnt",  32'(rq_d1.gnt_o), 32'd0);
    rst = 1'b1;
    tick();
    chk("d1_rst_req",  32'(mg_d1.req_o), 32'd0);
    chk("d1_rst_idx",  32'(mg_d1.idx_o), 32'd0);
    chk("d1_rst_lock", 32'(mg_d1.lock_o), 32'd0);
    chk("d1_rst_data", 32'(mg_d1.data_o), 32'd0);
    chk("d1_rst_gnt",  32'(rq_d1.gnt_o), 32'd0);
    rst = 1'b0; rq_d1.req_i = 4'b0110; rq_d1.lock_i = 4'b0000; mg_d1.gnt_i = 1'b1;
    #1;
    chk("d1_post_gnt", 32'(rq_d1.gnt_o), 32'b0010);
    tick();
    rq_d1.req_i = 4'b0000;

    // DEPTH=2 skid buffer: full rate, then a 3-cycle stall
    rq_d2.req_i = 4'b1111; mg_d2.gnt_i = 1'b1;
    #1;
    chk("d2_c0_gnt", 32'(rq_d2.gnt_o), 32'b0001);
    chk("d2_c0_req", 32'(mg_d2.req_o), 32'd0);
    tick();
    #1;
    chk("d2_c1_idx", 32'(mg_d2.idx_o), 32'd0);
    chk("d2_c1_gnt", 32'(rq_d2.gnt_o), 32'b0010);
    tick();
    #1;
    chk("d2_c2_idx", 32'(mg_d2.idx_o), 32'd1);
    chk("d2_c2_gnt", 32'(rq_d2.gnt_o), 32'b0100);
    tick();
    mg_d2.gnt_i = 1'b0;
    #1;
    chk("d2_s0_idx", 32'(mg_d2.idx_o), 32'd2);
    chk("d2_s0_gnt", 32'(rq_d2.gnt_o), 32'b1000);
    tick();
    #1;
    chk("d2_s1_gnt",  32'(rq_d2.gnt_o), 32'd0);
    chk("d2_s1_data", 32'(mg_d2.data_o), 32'hA2);
    tick();
    #1;
    chk("d2_s2_gnt", 32'(rq_d2.gnt_o), 32'd0);
    tick();
    mg_d2.gnt_i = 1'b1;
    #1;
    chk("d2_r0_idx", 32'(mg_d2.idx_o), 32'd2);
    chk("d2_r0_gnt", 32'(rq_d2.gnt_o), 32'd0);
    tick();
    #1;
    chk("d2_r1_idx", 32'(mg_d2.idx_o), 32'd3);
    chk("d2_r1_req", 32'(mg_d2.req_o), 32'd1);
    chk("d2_r1_gnt", 32'(rq_d2.gnt_o), 32'b0001);
    tick();
    #1;
    chk("d2_r2_idx",  32'(mg_d2.idx_o), 32'd0);
    chk("d2_r2_data", 32'(mg_d2.data_o), 32'hA0);
    rq_d2.req_i = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gnrc_rr_arbiter.md
# gnrc_rr_arbiter

N-to-1 request arbiter with per-transaction locking and payload multiplexing. It selects one of N requesters, forwards that requester's payload, lock flag and index to a single manager port, and routes the manager grant back to the winner. It is the arbitration core under the stream multiplexer and other shared-resource front ends in the generic connect library.

## Interface
- N, 1: number of requesters, must be ≥1.
- EXT_RR, 0: 1 = priority pointer comes from rr_i; 0 = internal round-robin pointer.
- LEAKY, 1: 1 = unlocked selection may change while req_o is pending; 0 = selection held from req_o rise until gnt_i.
- DEPTH, 0: output buffering, 0/1/2 (see Operation).
- DTYPE, logic: payload type.
- AW, $clog2(N) (1 if N=1): index width, derived; do not override.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of the internal pointer and lock state.
- rr_i  in  N  one-hot external priority start (EXT_RR=1); all-zero = index 0 first.
- req_i  in  N  request per requester.
- lock_i  in  N  per-requester "more beats follow" flag.
- gnt_o  out  N  one-hot grant to requesters.
- data_i  in  N×DTYPE  payload per requester.
- req_o  out  1  manager request.
- lock_o  out  1  lock flag of the forwarded beat.
- data_o  out  DTYPE  forwarded payload.
- idx_o  out  AW  index of the forwarded requester.
- gnt_i  in  1  manager grant.

## Operation
- Priority: search starts at the pointer index and wraps upward; the first asserted req_i wins. With EXT_RR=1 the pointer is the set bit of rr_i, or 0 when rr_i=0, which gives fixed priority with LSB highest.
- Internal pointer (EXT_RR=0): after a beat with lock=0 is accepted, the pointer becomes winner+1 mod N. Pointer reset value is 0.
- Lock: a beat accepted with lock=1 freezes the selection on that requester. Other requests are ignored until a beat with lock=0 from the same requester is accepted.
- Selection with LEAKY=0: once req_o asserts on an unlocked selection, that selection is held until gnt_i.
- gnt_o[idx] is asserted only when the winner's beat is taken into the output stage. gnt_o is zero when no request is pending.
- DEPTH=0: combinational path; req_o/data_o/lock_o/idx_o track the winner, and gnt_o = gnt_i routed to the winner.
- DEPTH=1: single output register. A new beat is accepted only when the register is empty or being drained by gnt_i in the same cycle. Arbitration for the next beat uses the pointer updated by the registered beat.
- DEPTH=2: two-entry skid buffer. Sustains one beat per cycle with gnt_i held high; gnt_o deasserts only when both entries are full.
- Once req_o is high in DEPTH≥1, data_o/lock_o/idx_o stay stable until gnt_i.
- flush_i: pointer is set to 0 and the lock is released; buffered beats are kept. flush_i has no effect when EXT_RR=1.

## Timing
- Reset values: req_o=0, gnt_o=0, lock_o=0, idx_o=0, data_o='0, pointer=0, lock released, buffers empty.
- Latency from req_i to req_o: 0 cycles for DEPTH=0, 1 cycle for DEPTH=1/2.
- Throughput: 1 beat/cycle for DEPTH=0/2. For DEPTH=1, 1 beat/cycle only while gnt_i stays high.
- Simultaneous flush_i and accept: flush wins; pointer=0 and lock released.
- Simultaneous rst_i with anything: reset wins.
- A locked requester that drops req_i keeps the lock; no other requester is served until it completes.

## Configuration
- GNRC_ARBITER_ASSERT_EN defined: simulation assertions are enabled.
  - Fatal error if N<1 at elaboration.
  - gnt_o must be one-hot or zero.
  - req_o must not fall without gnt_i.
  - data_o must be stable while req_o&&!gnt_i when DEPTH≥1 or LEAKY=0.
- GNRC_ARBITER_ASSERT_EN undefined: no checks; RTL behaviour is identical.

## Test plan
- N=4, EXT_RR=1, rr_i=0, DEPTH=0, req_i=4'b1010, gnt_i=1 -> idx_o=1, gnt_o=4'b0010, data_o=data_i[1].
- N=4, EXT_RR=0, DEPTH=0, all req_i high, lock_i=0, gnt_i=1 for 8 cycles -> idx_o sequence 0,1,2,3,0,1,2,3.
- N=4, req_i=4'b0011, requester 0 sends 3 beats with lock 1,1,0 while requester 1 waits -> idx_o=0 for 3 beats, then idx_o=1.
- DEPTH=1, gnt_i=0 with req_i[2]=1 -> req_o=1 one cycle later, idx_o=2, data_o held stable for 5 stalled cycles; gnt_o[2] pulses once.
- DEPTH=2, all req high, gnt_i=1 -> one beat per cycle; gnt_i=0 for 3 cycles -> exactly two beats buffered, then gnt_o=0.
- Mid-lock flush_i=1 on requester 0 with req_i=4'b0011 -> next arbitration from pointer 0 and lock released; rst_i mid-stream -> all outputs return to reset values the next cycle.
